// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Each bit is decided by a 3-sample majority vote around mid-bit.
module uart_rx_cfg #(
    parameter int unsigned UART_BAUD_RATE = 9600,
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY_MODE    = 0,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] ser_to_para,
    output logic                 flag_end,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / UART_BAUD_RATE;
    localparam int unsigned HALF     = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] SAMP0    = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SAMP1    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] DECIDE   = CNT_W'(HALF + 1);
    localparam logic [3:0]       LAST_DAT = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STP = 4'(STOP_BITS - 1);
    localparam logic             ODD_PAR  = (PARITY_MODE == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q, rx_s_q, rx_d_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q, data_q;
    logic                 s0_q, s1_q;
    logic                 par_err_q, frm_err_q;
    logic                 flag_q, par_out_q, frm_out_q;

    logic maj, exp_par, at_decide, at_wrap;

    always_comb begin
        maj       = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
        exp_par   = (^shift_q) ^ ODD_PAR;
        at_decide = (cnt_q == DECIDE);
        at_wrap   = (cnt_q == CNT_LAST);
        cnt_d     = at_wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            flag_q    <= 1'b0;
            par_out_q <= 1'b0;
            frm_out_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
            flag_q    <= 1'b0;

            if (state_q != S_IDLE) cnt_q <= cnt_d;
            if (cnt_q == SAMP0) s0_q <= rx_s_q;
            if (cnt_q == SAMP1) s1_q <= rx_s_q;

            case (state_q)
                S_IDLE: begin
                    if (rx_d_q && !rx_s_q) begin
                        state_q   <= S_START;
                        cnt_q     <= '0;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_decide && maj) begin
                        state_q <= S_IDLE;
                    end else if (at_wrap) begin
                        state_q   <= S_DATA;
                        bit_idx_q <= '0;
                    end
                end
                S_DATA: begin
                    if (at_decide) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                    if (at_wrap) begin
                        if (bit_idx_q == LAST_DAT) begin
                            bit_idx_q <= '0;
                            state_q   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_decide && (maj != exp_par)) par_err_q <= 1'b1;
                    if (at_wrap) state_q <= S_STOP;
                end
                S_STOP: begin
                    // The final stop bit completes the frame at mid-bit so the
                    // next start edge can be caught without any idle gap.
                    if (at_decide) begin
                        if (!maj) frm_err_q <= 1'b1;
                        if (bit_idx_q == LAST_STP) begin
                            data_q    <= shift_q;
                            par_out_q <= par_err_q;
                            frm_out_q <= frm_err_q | ~maj;
                            flag_q    <= 1'b1;
                            state_q   <= maj ? S_IDLE : S_BREAK;
                        end
                    end else if (at_wrap) begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ser_to_para = data_q;
    assign flag_end    = flag_q;
    assign parity_err  = par_out_q;
    assign frame_err   = frm_out_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 5O2) at 16 clocks per bit.
module tb_uart_rx_cfg;

    localparam int unsigned BD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst;
    logic       rx_a, rx_b, rx_c;
    logic [7:0] ser_a, ser_b;
    logic [4:0] ser_c;
    logic       flag_a, flag_b, flag_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;
    logic       busy_a, busy_b, busy_c;

    int unsigned cyc = 0;
    int unsigned tests_run = 0;
    int unsigned fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.UART_BAUD_RATE(100_000), .CLK_FREQ(1_600_000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .sys_clk(clk), .sys_rst(sys_rst), .rx(rx_a), .ser_to_para(ser_a),
        .flag_end(flag_a), .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a));

    uart_rx_cfg #(.UART_BAUD_RATE(100_000), .CLK_FREQ(1_600_000), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(1)) u_b (
        .sys_clk(clk), .sys_rst(sys_rst), .rx(rx_b), .ser_to_para(ser_b),
        .flag_end(flag_b), .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b));

    uart_rx_cfg #(.UART_BAUD_RATE(100_000), .CLK_FREQ(1_600_000), .DATA_BITS(5),
                  .PARITY_MODE(1), .STOP_BITS(2)) u_c (
        .sys_clk(clk), .sys_rst(sys_rst), .rx(rx_c), .ser_to_para(ser_c),
        .flag_end(flag_c), .parity_err(pe_c), .frame_err(fe_c), .busy(busy_c));

    typedef struct {
        logic [8:0]  d;
        logic        pe;
        logic        fe;
        int unsigned cyc;
    } ev_t;

    ev_t qa[$], qb[$], qc[$];

    // Every cycle flag_end is high is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (flag_a === 1'b1) qa.push_back(ev_t'{d: 9'(ser_a), pe: pe_a, fe: fe_a, cyc: cyc});
        if (flag_b === 1'b1) qb.push_back(ev_t'{d: 9'(ser_b), pe: pe_b, fe: fe_b, cyc: cyc});
        if (flag_c === 1'b1) qc.push_back(ev_t'{d: 9'(ser_c), pe: pe_c, fe: fe_c, cyc: cyc});
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int unsigned which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send(input int unsigned which, input logic [15:0] bits, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            set_rx(which, bits[i]);
            tick(BD);
        end
    endtask

    task automatic test_reset();
        tests_run++; if (ser_a !== 8'h00) begin fails++; $display("FAIL reset_ser_a got %h want 00", ser_a); end
        tests_run++; if (flag_a !== 1'b0) begin fails++; $display("FAIL reset_flag_a got %b want 0", flag_a); end
        tests_run++; if (pe_a !== 1'b0) begin fails++; $display("FAIL reset_pe_a got %b want 0", pe_a); end
        tests_run++; if (fe_a !== 1'b0) begin fails++; $display("FAIL reset_fe_a got %b want 0", fe_a); end
        tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
        tests_run++; if (ser_c !== 5'h00) begin fails++; $display("FAIL reset_ser_c got %h want 00", ser_c); end
        tests_run++; if (busy_c !== 1'b0) begin fails++; $display("FAIL reset_busy_c got %b want 0", busy_c); end
    endtask

    task automatic test_single();
        int unsigned c;
        ev_t ev;
        qa.delete();
        c = cyc;
        send(0, {6'b0, 1'b1, 8'hEF, 1'b0}, 10);
        tick(20);
        tests_run++;
        if (qa.size() != 1) begin
            fails++; $display("FAIL single_count got %0d want 1", qa.size());
        end else begin
            ev = qa.pop_front();
            tests_run++; if (ev.d !== 9'h0EF) begin fails++; $display("FAIL single_data got %h want ef", ev.d); end
            tests_run++; if (ev.pe !== 1'b0) begin fails++; $display("FAIL single_pe got %b want 0", ev.pe); end
            tests_run++; if (ev.fe !== 1'b0) begin fails++; $display("FAIL single_fe got %b want 0", ev.fe); end
            tests_run++; if (ev.cyc !== c + 157) begin fails++; $display("FAIL single_latency got %0d want %0d", ev.cyc - c, 157); end
        end
        tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL single_busy_after got %b want 0", busy_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        ev_t ev;
        int unsigned prev;
        bytes = '{8'hEF, 8'hFA, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        qa.delete();
        for (int i = 0; i < 8; i++) send(0, {6'b0, 1'b1, bytes[i], 1'b0}, 10);
        tick(20);
        tests_run++;
        if (qa.size() != 8) begin
            fails++; $display("FAIL b2b_count got %0d want 8", qa.size());
        end else begin
            prev = 0;
            for (int i = 0; i < 8; i++) begin
                ev = qa.pop_front();
                tests_run++;
                if (ev.d !== {1'b0, bytes[i]} || ev.fe !== 1'b0 || ev.pe !== 1'b0) begin
                    fails++; $display("FAIL b2b_frame%0d got d=%h pe=%b fe=%b want d=%h pe=0 fe=0", i, ev.d, ev.pe, ev.fe, bytes[i]);
                end
                if (i > 0) begin
                    tests_run++;
                    if (ev.cyc - prev !== 160) begin fails++; $display("FAIL b2b_spacing%0d got %0d want 160", i, ev.cyc - prev); end
                end
                prev = ev.cyc;
            end
        end
    endtask

    task automatic test_parity();
        ev_t ev;
        for (int p = 0; p < 2; p++) begin
            qb.delete();
            send(1, {5'b0, 1'b1, 1'(p), 8'h03, 1'b0}, 11);
            tick(20);
            tests_run++;
            if (qb.size() != 1) begin
                fails++; $display("FAIL parity%0d_count got %0d want 1", p, qb.size());
            end else begin
                ev = qb.pop_front();
                tests_run++; if (ev.pe !== 1'(p)) begin fails++; $display("FAIL parity%0d_pe got %b want %0d", p, ev.pe, p); end
                tests_run++; if (ev.d !== 9'h003) begin fails++; $display("FAIL parity%0d_data got %h want 03", p, ev.d); end
                tests_run++; if (ev.fe !== 1'b0) begin fails++; $display("FAIL parity%0d_fe got %b want 0", p, ev.fe); end
            end
        end
    endtask

    task automatic test_framing();
        ev_t ev;
        qa.delete();
        send(0, {6'b0, 1'b0, 8'h0F, 1'b0}, 10);
        tick(3 * BD);
        tests_run++; if (busy_a !== 1'b1) begin fails++; $display("FAIL break_busy got %b want 1", busy_a); end
        tests_run++;
        if (qa.size() != 1) begin
            fails++; $display("FAIL frame_count got %0d want 1", qa.size());
        end else begin
            ev = qa.pop_front();
            tests_run++; if (ev.fe !== 1'b1) begin fails++; $display("FAIL frame_fe got %b want 1", ev.fe); end
            tests_run++; if (ev.d !== 9'h00F) begin fails++; $display("FAIL frame_data got %h want 0f", ev.d); end
        end
        set_rx(0, 1'b1);
        tick(2 * BD);
        tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL break_release_busy got %b want 0", busy_a); end
        send(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        tick(20);
        tests_run++;
        if (qa.size() != 1) begin
            fails++; $display("FAIL recover_count got %0d want 1", qa.size());
        end else begin
            ev = qa.pop_front();
            tests_run++;
            if (ev.d !== 9'h055 || ev.fe !== 1'b0) begin
                fails++; $display("FAIL recover_frame got d=%h fe=%b want d=55 fe=0", ev.d, ev.fe);
            end
        end
    endtask

    task automatic test_glitch();
        ev_t ev;
        qa.delete();
        set_rx(0, 1'b0);
        tick(4);
        tests_run++; if (busy_a !== 1'b1) begin fails++; $display("FAIL glitch_busy_start got %b want 1", busy_a); end
        tick(1);
        set_rx(0, 1'b1);
        tick(9);
        tests_run++; if (busy_a !== 1'b0) begin fails++; $display("FAIL glitch_busy_end got %b want 0", busy_a); end
        tick(40);
        tests_run++; if (qa.size() != 0) begin fails++; $display("FAIL glitch_noflag got %0d want 0", qa.size()); end

        set_rx(0, 1'b0); tick(BD);
        tick(9);
        set_rx(0, 1'b1); tick(1);
        set_rx(0, 1'b0); tick(6);
        tick(7 * BD);
        set_rx(0, 1'b1); tick(BD);
        tick(20);
        tests_run++;
        if (qa.size() != 1) begin
            fails++; $display("FAIL spike_count got %0d want 1", qa.size());
        end else begin
            ev = qa.pop_front();
            tests_run++;
            if (ev.d !== 9'h000 || ev.fe !== 1'b0) begin
                fails++; $display("FAIL spike_frame got d=%h fe=%b want d=00 fe=0", ev.d, ev.fe);
            end
        end
    endtask

    task automatic test_cfg5();
        ev_t ev;
        int unsigned c;
        qc.delete();
        c = cyc;
        send(2, {7'b0, 2'b11, 1'b0, 5'h1A, 1'b0}, 9);
        tick(20);
        tests_run++;
        if (qc.size() != 1) begin
            fails++; $display("FAIL cfg5_count got %0d want 1", qc.size());
        end else begin
            ev = qc.pop_front();
            tests_run++;
            if (ev.d !== 9'h01A || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
                fails++; $display("FAIL cfg5_frame got d=%h pe=%b fe=%b want d=1a pe=0 fe=0", ev.d, ev.pe, ev.fe);
            end
            tests_run++; if (ev.cyc !== c + 141) begin fails++; $display("FAIL cfg5_latency got %0d want 141", ev.cyc - c); end
        end

        send(2, {7'b0, 2'b01, 1'b0, 5'h1A, 1'b0}, 9);
        set_rx(2, 1'b1);
        tick(2 * BD);
        tests_run++;
        if (qc.size() != 1) begin
            fails++; $display("FAIL cfg5_stop2_count got %0d want 1", qc.size());
        end else begin
            ev = qc.pop_front();
            tests_run++;
            if (ev.fe !== 1'b1 || ev.d !== 9'h01A) begin
                fails++; $display("FAIL cfg5_stop2_frame got d=%h fe=%b want d=1a fe=1", ev.d, ev.fe);
            end
        end

        send(2, {7'b0, 2'b11, 1'b1, 5'h05, 1'b0}, 4);
        set_rx(2, 1'b0);
        tick(8);
        sys_rst = 1'b1;
        set_rx(2, 1'b1);
        tick(1);
        tests_run++;
        if (ser_c !== 5'h00 || flag_c !== 1'b0 || pe_c !== 1'b0 || fe_c !== 1'b0 || busy_c !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs got ser=%h flag=%b pe=%b fe=%b busy=%b want all 0", ser_c, flag_c, pe_c, fe_c, busy_c);
        end
        sys_rst = 1'b0;
        tick(2 * BD);
        tests_run++; if (qc.size() != 0) begin fails++; $display("FAIL midreset_noflag got %0d want 0", qc.size()); end

        send(2, {7'b0, 2'b11, 1'b1, 5'h05, 1'b0}, 9);
        tick(20);
        tests_run++;
        if (qc.size() != 1) begin
            fails++; $display("FAIL after_reset_count got %0d want 1", qc.size());
        end else begin
            ev = qc.pop_front();
            tests_run++;
            if (ev.d !== 9'h005 || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
                fails++; $display("FAIL after_reset_frame got d=%h pe=%b fe=%b want d=05 pe=0 fe=0", ev.d, ev.pe, ev.fe);
            end
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        rx_c = 1'b1;
        tick(3);
        sys_rst = 1'b0;
        test_reset();
        tick(4);
        test_single();
        test_back_to_back();
        test_parity();
        test_framing();
        test_glitch();
        test_cfg5();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
